// File: rtl/trng_pkg.sv
// Shared types and sizing helpers for the TRNG conditioner.
// Optional raw-bypass path is enabled with the TRNG_RAW_BYPASS_EN macro.
package trng_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2,
    FAIL   = 2'd3
  } trng_state_t;

  localparam int DEF_SIZE          = 8;
  localparam int DEF_WARMUP_CYCLES = 64;
  localparam int DEF_REP_LIMIT     = 16;

  // Bits needed to hold a counter that reaches max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/trng_health_rct.sv
// Repetition-count health test: counts consecutive identical raw samples
// and pulses fail in the cycle the count reaches REP_LIMIT.
module trng_health_rct
  import trng_pkg::*;
#(
  parameter int SIZE      = DEF_SIZE,
  parameter int REP_LIMIT = DEF_REP_LIMIT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic [SIZE-1:0] raw_q,
  input  logic [SIZE-1:0] prev_q,
  output logic            fail
);

  localparam int RW = cnt_width(REP_LIMIT);

  logic [RW-1:0] rep_reg;
  logic [RW-1:0] rep_next;

  // Next repetition count; a zero count means the run just started.
  always_comb begin
    rep_next = rep_reg;
    fail     = 1'b0;
    if (!clear) begin
      if ((rep_reg != '0) && (raw_q == prev_q)) begin
        if (rep_reg < RW'(REP_LIMIT)) rep_next = rep_reg + RW'(1);
      end else begin
        rep_next = RW'(1);
      end
      fail = (rep_next == RW'(REP_LIMIT));
    end
  end

  // Repetition counter register, zeroed whenever the test is inactive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rep_reg <= '0;
    else if (clear) rep_reg <= '0;
    else            rep_reg <= rep_next;
  end

endmodule

// File: rtl/trng_conditioner.sv
// TRNG conditioner: RO enable control, health test, von Neumann debiasing
// and word packing onto a valid/ready output.
// Optional macro TRNG_RAW_BYPASS_EN adds raw_mode to pass raw samples through.
module trng_conditioner
  import trng_pkg::*;
#(
  parameter int SIZE          = DEF_SIZE,
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int REP_LIMIT     = DEF_REP_LIMIT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  output logic            ro_en,
  input  logic [SIZE-1:0] raw_in,
`ifdef TRNG_RAW_BYPASS_EN
  input  logic            raw_mode,
`endif
  output logic [SIZE-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            health_fail
);

  localparam int WW = cnt_width(WARMUP_CYCLES);
  localparam int BW = cnt_width(SIZE);

  trng_state_t     state_reg, state_next;
  logic [WW-1:0]   warm_reg;
  logic [SIZE-1:0] raw_q, prev_q;
  logic            phase_reg, a_reg;
  logic [SIZE-1:0] shift_reg;
  logic [BW-1:0]   bit_cnt_reg;
  logic [SIZE-1:0] out_data_reg;
  logic            out_valid_reg;
  logic            bypass_mode;

  logic run, fail_pulse, b_bit, emit, word_full, buf_free, take;
  logic load_vn, load_byp;

  assign run       = (state_reg == RUN);
  assign b_bit     = ^raw_q;
  assign take      = out_valid_reg && out_ready;
  assign buf_free  = !out_valid_reg || out_ready;
  assign word_full = (bit_cnt_reg == BW'(SIZE));
  assign emit      = run && !fail_pulse && !bypass_mode && phase_reg && (a_reg != b_bit);
  assign load_vn   = run && !bypass_mode && word_full && buf_free;
  assign load_byp  = run && bypass_mode && !fail_pulse && buf_free;

  assign ro_en       = (state_reg == WARMUP) || (state_reg == RUN);
  assign health_fail = (state_reg == FAIL);
  assign out_data    = out_data_reg;
  assign out_valid   = out_valid_reg;

  trng_health_rct #(.SIZE(SIZE), .REP_LIMIT(REP_LIMIT)) u_rct (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!run),
    .raw_q  (raw_q),
    .prev_q (prev_q),
    .fail   (fail_pulse)
  );

`ifdef TRNG_RAW_BYPASS_EN
  logic bypass_mode_reg;
  // Mode is only sampled at a word boundary so a half-built word is never mixed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 bypass_mode_reg <= 1'b0;
    else if (bit_cnt_reg == '0) bypass_mode_reg <= raw_mode;
  end
  assign bypass_mode = bypass_mode_reg;
`else
  assign bypass_mode = 1'b0;
`endif

  // FSM next state; dropping en always returns to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (en) state_next = WARMUP;
      WARMUP:  if (warm_reg == WW'(WARMUP_CYCLES - 1)) state_next = RUN;
      RUN:     if (fail_pulse) state_next = FAIL;
      FAIL:    state_next = FAIL;
      default: state_next = IDLE;
    endcase
    if (!en) state_next = IDLE;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Warm-up counter; restarts from zero each time WARMUP is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    warm_reg <= '0;
    else if (state_reg != WARMUP)  warm_reg <= '0;
    else                           warm_reg <= warm_reg + WW'(1);
  end

  // Raw sample pipeline feeding both the health test and the extractor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q  <= '0;
      prev_q <= '0;
    end else begin
      raw_q  <= raw_in;
      prev_q <= raw_q;
    end
  end

  // Von Neumann pairing and packing; state is discarded outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg   <= 1'b0;
      a_reg       <= 1'b0;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else if (!run || bypass_mode) begin
      phase_reg   <= 1'b0;
      a_reg       <= 1'b0;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else begin
      if (!fail_pulse) begin
        phase_reg <= ~phase_reg;
        if (!phase_reg) a_reg <= b_bit;
      end
      if (load_vn) begin
        bit_cnt_reg <= '0;
      end else if (emit && !word_full) begin
        shift_reg   <= {shift_reg[SIZE-2:0], a_reg};
        bit_cnt_reg <= bit_cnt_reg + BW'(1);
      end
    end
  end

  // Output buffer: a new word may load in the same cycle the old one is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else if (load_vn) begin
      out_data_reg  <= shift_reg;
      out_valid_reg <= 1'b1;
    end else if (load_byp) begin
      out_data_reg  <= raw_q;
      out_valid_reg <= 1'b1;
    end else if (take) begin
      out_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trng_conditioner.sv
// Scoreboard bench for trng_conditioner: expected words are queued when
// stimulus is built, a monitor pops and compares on every transfer.
module tb_trng_conditioner;

  localparam int SIZE = 8;
  localparam int WARM = 64;
  localparam int REP  = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            ro_en;
  logic [SIZE-1:0] raw_in;
  logic [SIZE-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            health_fail;
`ifdef TRNG_RAW_BYPASS_EN
  logic            raw_mode;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int xfer_count  = 0;

  logic [SIZE-1:0] exp_q[$];
  logic [SIZE-1:0] samples[$];
  logic [SIZE-1:0] model_words[$];
  logic [SIZE-1:0] mon_exp;
  logic [7:0]      pat_bits;
  logic [SIZE-1:0] w1, w2;

  trng_conditioner #(.SIZE(SIZE), .WARMUP_CYCLES(WARM), .REP_LIMIT(REP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .ro_en       (ro_en),
    .raw_in      (raw_in),
`ifdef TRNG_RAW_BYPASS_EN
    .raw_mode    (raw_mode),
`endif
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .health_fail (health_fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SIZE-1:0] with_par(input logic p);
    logic [SIZE-1:0] v;
    v = SIZE'($urandom);
    if ((^v) != p) v[0] = ~v[0];
    return v;
  endfunction

  // Reference: von Neumann over consecutive pairs of RUN samples, 8 bits per word,
  // first emitted bit ends up as the MSB.
  task automatic model_vn();
    int nbits;
    logic [SIZE-1:0] w;
    logic p0, p1;
    nbits = 0;
    w = '0;
    model_words.delete();
    for (int k = 0; k + 1 < samples.size(); k += 2) begin
      p0 = ^samples[k];
      p1 = ^samples[k+1];
      if (p0 != p1) begin
        w = {w[SIZE-2:0], p0};
        nbits++;
        if (nbits == SIZE) begin
          model_words.push_back(w);
          nbits = 0;
        end
      end
    end
  endtask

  task automatic add_tail();
    for (int i = 0; i < 8; i++) samples.push_back(with_par(1'b0));
  endtask

  // Raise en and spend the warm-up period on don't-care samples.
  task automatic start_run();
    en = 1'b1;
    raw_in = SIZE'($urandom);
    check("ro_en_before_edge", ro_en, 0);
    for (int i = 0; i < WARM; i++) begin
      raw_in = SIZE'($urandom);
      tick();
      if (i == 0) check("ro_en_after_en", ro_en, 1);
    end
  endtask

  // mode 1: latency check, 2: stall stability, 3: health stays quiet
  task automatic drive(input int mode, input logic [SIZE-1:0] hold_word);
    for (int j = 0; j < samples.size(); j++) begin
      raw_in = samples[j];
      tick();
      if (mode == 1 && j <= 2*SIZE+1) check("first_valid_latency", out_valid, (j == 2*SIZE+1));
      if (mode == 2 && j >= 2*SIZE+1) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, hold_word);
      end
      if (mode == 3) check("health_quiet", health_fail, 0);
    end
  endtask

  task automatic stop_run();
    en = 1'b0;
    raw_in = SIZE'($urandom);
    repeat (5) tick();
  endtask

  // Monitor: a transfer happens at the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      xfer_count++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_word: got %02h expected none", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        $display("xfer %0d: data=%02h expected=%02h", xfer_count, out_data, mon_exp);
        check("word", out_data, mon_exp);
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; out_ready = 1'b0; raw_in = '0;
`ifdef TRNG_RAW_BYPASS_EN
    raw_mode = 1'b0;
`endif
    #1;
    check("rst_ro_en", ro_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_health_fail", health_fail, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("idle_ro_en", ro_en, 0);
    check("idle_out_valid", out_valid, 0);

    // A: all-differing pairs first, then random; minimum latency to first word
    samples.delete();
    for (int i = 0; i < 2*SIZE; i++) begin
      logic p;
      p = 1'($urandom);
      samples.push_back(with_par(p));
      samples.push_back(with_par(~p));
    end
    for (int i = 0; i < 100; i++) samples.push_back(SIZE'($urandom));
    add_tail();
    model_vn();
    foreach (model_words[i]) exp_q.push_back(model_words[i]);
    out_ready = 1'b1;
    start_run();
    drive(1, '0);
    stop_run();
    check("drain_A", exp_q.size(), 0);

    // B: parity pattern 0,1,1,0,0,0,1,1 gives bits 0,1 per 8 samples -> 8'h55 words
    samples.delete();
    pat_bits = 8'b0110_0011;
    for (int r = 0; r < 8; r++)
      for (int i = 0; i < 8; i++) samples.push_back(with_par(pat_bits[7-i]));
    add_tail();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h55);
    start_run();
    drive(0, '0);
    stop_run();
    check("drain_B", exp_q.size(), 0);

    // C: backpressure for 200 cycles, then release -> transfer + same-cycle reload
    samples.delete();
    for (int i = 0; i < 100; i++) begin
      logic p;
      p = 1'($urandom);
      samples.push_back(with_par(p));
      samples.push_back(with_par(~p));
    end
    model_vn();
    w1 = model_words[0];
    w2 = model_words[1];
    exp_q.push_back(w1);
    exp_q.push_back(w2);
    out_ready = 1'b0;
    start_run();
    drive(2, w1);
    out_ready = 1'b1;
    raw_in = SIZE'($urandom);
    tick();
    check("reload_valid", out_valid, 1);
    check("reload_data", out_data, w2);
    raw_in = SIZE'($urandom);
    tick();
    check("after_second_xfer_valid", out_valid, 0);
    out_ready = 1'b0;
    stop_run();
    check("drain_C", exp_q.size(), 0);

    // D: asynchronous reset in the middle of RUN with a word pending
    samples.delete();
    for (int i = 0; i < 20; i++) begin
      logic p;
      p = 1'($urandom);
      samples.push_back(with_par(p));
      samples.push_back(with_par(~p));
    end
    start_run();
    drive(0, '0);
    check("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_ro_en", ro_en, 0);
    check("midrun_rst_out_valid", out_valid, 0);
    check("midrun_rst_out_data", out_data, 0);
    check("midrun_rst_health_fail", health_fail, 0);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // E: constant 8'hA5 for REP_LIMIT samples trips the health test
    samples.delete();
    for (int i = 0; i < REP; i++) samples.push_back(8'hA5);
    out_ready = 1'b1;
    start_run();
    drive(3, '0);
    raw_in = SIZE'($urandom);
    tick();
    check("health_fail_set", health_fail, 1);
    check("fail_ro_en", ro_en, 0);
    repeat (3) begin
      raw_in = SIZE'($urandom);
      tick();
    end
    check("health_fail_sticky", health_fail, 1);
    check("fail_no_word", out_valid, 0);
    en = 1'b0;
    tick();
    check("health_fail_cleared", health_fail, 0);
    check("idle_after_fail_ro_en", ro_en, 0);
    en = 1'b1;
    tick();
    check("warmup_restart_ro_en", ro_en, 1);
    check("warmup_restart_hf", health_fail, 0);
    stop_run();

    // F: fully random samples with the consumer always ready
    samples.delete();
    for (int i = 0; i < 300; i++) samples.push_back(SIZE'($urandom));
    add_tail();
    model_vn();
    foreach (model_words[i]) exp_q.push_back(model_words[i]);
    start_run();
    drive(0, '0);
    stop_run();
    check("drain_F", exp_q.size(), 0);

`ifdef TRNG_RAW_BYPASS_EN
    // G: raw bypass, every RUN sample becomes a word two cycles later
    samples.delete();
    samples.push_back(8'h3C);
    for (int i = 0; i < 20; i++) samples.push_back(SIZE'($urandom));
    foreach (samples[i]) exp_q.push_back(samples[i]);
    raw_mode = 1'b1;
    start_run();
    drive(0, '0);
    stop_run();
    raw_mode = 1'b0;
    check("drain_G", exp_q.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
